// File: rtl/core_run_controller.sv
// Run-control sequencer for the single-cycle RV32I core: program load into
// instruction memory, then run / halt / single-step / resume of the core.
module core_run_controller #(
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_WORDS  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_start,
  input  logic                  ld_valid,
  input  logic [31:0]           ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  input  logic                  halt_req,
  input  logic                  step_req,
  input  logic                  resume_req,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  core_en,
  output logic [2:0]            state,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [31:0]           cycle_count,
  output logic                  load_err
);

  // state | meaning
  // IDLE  | core held in reset, waiting for a load or resume
  // LOAD  | core held in reset, loader streaming words into imem
  // RUN   | core advancing every cycle
  // HALT  | core frozen, state preserved
  // STEP  | core advances for exactly one cycle, then back to HALT
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    HALT = 3'd3,
    STEP = 3'd4
  } state_t;

  localparam logic [ADDR_WIDTH:0] MaxWords = (ADDR_WIDTH+1)'(MAX_WORDS);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
  logic [31:0]           cycle_count_q, cycle_count_d;
  logic                  load_err_q, load_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      word_count_q  <= '0;
      cycle_count_q <= '0;
      load_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      word_count_q  <= word_count_d;
      cycle_count_q <= cycle_count_d;
      load_err_q    <= load_err_d;
    end
  end

  // ld_ready gates on word_count, so word_count saturates at MaxWords
  assign ld_ready    = (state_q == LOAD) && (word_count_q < MaxWords);
  assign imem_we     = ld_valid & ld_ready;
  assign imem_addr   = word_count_q[ADDR_WIDTH-1:0];
  assign imem_wdata  = ld_data;
  assign core_rst    = (state_q == IDLE) || (state_q == LOAD);
  assign core_en     = (state_q == RUN) || (state_q == STEP);
  assign state       = state_q;
  assign word_count  = word_count_q;
  assign cycle_count = cycle_count_q;
  assign load_err    = load_err_q;

  always_comb begin
    state_d       = state_q;
    word_count_d  = word_count_q;
    cycle_count_d = cycle_count_q;
    load_err_d    = load_err_q;
    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d       = LOAD;
          word_count_d  = '0;
          cycle_count_d = '0;
          load_err_d    = 1'b0;
        end else if (resume_req) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (imem_we) begin
          word_count_d = word_count_q + 1'b1;
          if (ld_last) state_d = RUN;
        end else if (word_count_q == MaxWords) begin
          load_err_d = 1'b1;
          state_d    = IDLE;
        end
      end
      RUN: begin
        cycle_count_d = cycle_count_q + 32'd1;
        if (load_start) begin
          state_d       = LOAD;
          word_count_d  = '0;
          cycle_count_d = '0;
          load_err_d    = 1'b0;
        end else if (halt_req) begin
          state_d = HALT;
        end
      end
      HALT: begin
        if (load_start) begin
          state_d       = LOAD;
          word_count_d  = '0;
          cycle_count_d = '0;
          load_err_d    = 1'b0;
        end else if (resume_req) begin
          state_d = RUN;
        end else if (step_req) begin
          state_d = STEP;
        end
      end
      STEP: begin
        cycle_count_d = cycle_count_q + 32'd1;
        state_d       = HALT;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/core_run_controller.md
Name: core_run_controller

Overview:
- Run-control sequencer for the single-cycle RV32I core.
- Holds the core in reset while a host loader streams a program into instruction memory over a valid/ready port.
- Releases the core to run, then supports halt, single-step and resume.
- Sits between the host/debug interface and the core top: drives the core reset, a global core enable (gates PC update, register-file write and data-memory write) and the instruction-memory write port.

Parameters:
- ADDR_WIDTH, 8, instruction-memory word-address width.
- MAX_WORDS, 256, maximum program length in 32-bit words (must be <= 2^ADDR_WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_start  in  1  request a new program load.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader instruction word.
- ld_last  in  1  qualifies the final word of the program.
- ld_ready  out  1  controller accepts the loader word this cycle.
- halt_req  in  1  stop the core after the current cycle.
- step_req  in  1  execute exactly one core cycle while halted.
- resume_req  in  1  run freely (from IDLE: run the existing image).
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  ADDR_WIDTH  instruction-memory word address.
- imem_wdata  out  32  instruction-memory write data.
- core_rst  out  1  reset to the core (PC, register file, data memory).
- core_en  out  1  core advance enable.
- state  out  3  encoded FSM state.
- word_count  out  ADDR_WIDTH+1  words written in the current/last load.
- cycle_count  out  32  core cycles executed since the last load.
- load_err  out  1  sticky overflow flag.

Behaviour:
- Clock and reset: one clock domain (clk). rst is synchronous, active-high, evaluated only on the rising edge of clk.
- State encoding: IDLE=0, LOAD=1, RUN=2, HALT=3, STEP=4. All state and counters are registered.
- Reset values: state=IDLE, word_count=0, cycle_count=0, load_err=0. With those values: core_rst=1, core_en=0, ld_ready=0, imem_we=0, imem_addr=0.
- Output decode (combinational from registered state and inputs only):
  - core_rst=1 in IDLE and LOAD, else 0.
  - core_en=1 in RUN and STEP, else 0.
  - ld_ready=1 in LOAD when word_count<MAX_WORDS.
  - imem_we = ld_valid & ld_ready.
  - imem_addr = word_count[ADDR_WIDTH-1:0]; imem_wdata = ld_data.
- Write latency: zero. The word is written in the handshake cycle; word_count increments on that edge.
- IDLE:
  - load_start -> LOAD: clear word_count, cycle_count and load_err.
  - else resume_req -> RUN.
- LOAD:
  - Handshake with ld_last=1 -> RUN next cycle; the core leaves reset on that edge with the image complete.
  - If word_count==MAX_WORDS and no last has been accepted: ld_ready=0, set load_err, -> IDLE.
  - load_start while in LOAD is ignored.
- RUN: cycle_count+1 every cycle.
  - Priority: load_start -> LOAD (clear counters; core_rst=1 from the next cycle), else halt_req -> HALT.
  - In the halt_req cycle the core still executes (core_en=1); it is frozen from the next cycle.
- HALT: core_rst=0, core_en=0, so core state is preserved.
  - Priority: load_start -> LOAD, else resume_req -> RUN, else step_req -> STEP.
- STEP: core_en=1 for exactly one cycle, cycle_count+1, then unconditionally -> HALT.
  - All requests arriving during STEP are ignored.
  - A held step_req produces one step every two cycles.
- Counters: cycle_count wraps 0xFFFFFFFF -> 0. word_count saturates at MAX_WORDS.
- Reset mid-operation: rst during LOAD returns to IDLE with word_count=0. Memory already written keeps the partial image, and no imem_we is asserted in the reset cycle's response.
- load_err clears only on rst or on entering LOAD.

Test Plan:
- Reset: after rst, check state=0, core_rst=1, core_en=0, ld_ready=0, counters 0.
- 4-word load: load_start, then stream 0x00500093, 0x00300113, 0x002081B3, 0x00000013 with last on word 3, back-to-back valid.
  - imem_we asserted on 4 consecutive cycles at addr 0..3; word_count=4.
  - Next cycle: state=RUN, core_rst=0, core_en=1. After 10 RUN cycles, x3=8 and cycle_count=10.
- Loader stalls: ld_valid low on alternate cycles. Writes occur only on valid cycles, addresses stay contiguous, no duplicated or skipped address.
- Halt/step/resume:
  - halt_req in RUN at cycle_count=5 -> HALT with cycle_count=6; PC is frozen.
  - step_req -> exactly one core_en pulse, cycle_count=7, state returns to 3.
  - step_req and resume_req together -> RUN.
- Overflow with MAX_WORDS=4: stream 5 words with no last. 4 words are written, ld_ready drops, load_err=1, state=IDLE, core_rst remains 1.
- Priority and mid-load reset:
  - load_start and halt_req together in RUN -> LOAD, cycle_count=0.
  - rst after 2 of 4 words -> IDLE, word_count=0; a fresh load then writes from addr 0.
